// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer for the 4-stage VLIW pipeline: turns hazard verdicts
// into per-stage enables, bubble/flush strobes and saturating performance counters.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_PENALTY = 1,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipeline_stall,
  input  logic [1:0]           stall_cycles,
  input  logic                 pipeline_flush,
  input  logic                 mem_ready,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 execute_en,
  output logic                 writeback_en,
  output logic                 execute_bubble,
  output logic                 flush_fetch,
  output logic                 flush_decode,
  output logic [1:0]           ctrl_state,
  output logic [1:0]           stall_remaining,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] freeze_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] PEN_INIT   = 2'(FLUSH_PENALTY - 1);
  localparam state_e     FLUSH_NEXT = (FLUSH_PENALTY > 1) ? ST_FLUSH : ST_RUN;

  state_e               state_q, state_d;
  logic [1:0]           rem_q, rem_d;
  logic [1:0]           pen_q, pen_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;

  logic active;
  logic take_flush;
  logic stall_mode;
  logic freeze;

  // Flush overrides everything except freeze/reset; stalls only act in RUN or STALL.
  always_comb begin
    active     = !rst && mem_ready;
    freeze     = !rst && !mem_ready;
    take_flush = active && pipeline_flush;
    stall_mode = active && !pipeline_flush &&
                 ((state_q == ST_STALL) || ((state_q == ST_RUN) && pipeline_stall));
  end

  always_comb begin
    fetch_en       = active && !stall_mode;
    decode_en      = active && !stall_mode;
    execute_en     = active;
    writeback_en   = active;
    execute_bubble = take_flush || stall_mode || (active && (state_q == ST_FLUSH));
    flush_fetch    = take_flush;
    flush_decode   = take_flush;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pen_d   = pen_q;
    if (active) begin
      if (pipeline_flush) begin
        state_d = FLUSH_NEXT;
        pen_d   = PEN_INIT;
        rem_d   = '0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (pipeline_stall && (stall_cycles > 2'd1)) begin
              state_d = ST_STALL;
              rem_d   = stall_cycles - 2'd1;
            end
          end
          ST_STALL: begin
            if (rem_q <= 2'd1) begin
              state_d = ST_RUN;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 2'd1;
            end
          end
          ST_FLUSH: begin
            if (pen_q <= 2'd1) begin
              state_d = ST_RUN;
              pen_d   = '0;
            end else begin
              pen_d = pen_q - 2'd1;
            end
          end
          default: begin
            state_d = ST_RUN;
            rem_d   = '0;
            pen_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall_mode && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (take_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
    if (freeze && (freeze_cnt_q != '1)) begin
      freeze_cnt_d = freeze_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      rem_q        <= '0;
      pen_q        <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      pen_q        <= pen_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  always_comb begin
    ctrl_state      = state_q;
    stall_remaining = rem_q;
    stall_count     = stall_cnt_q;
    flush_count     = flush_cnt_q;
    freeze_count    = freeze_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: table of per-cycle vectors on a
// FLUSH_PENALTY=1 instance, plus hand sequences on a FLUSH_PENALTY=3, 4-bit-counter instance.
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       pipeline_stall;
  logic [1:0] stall_cycles;
  logic       pipeline_flush;
  logic       mem_ready;

  logic        a_fe, a_de, a_ee, a_we, a_bub, a_ff, a_fd;
  logic [1:0]  a_state, a_rem;
  logic [31:0] a_sc, a_fc, a_fz;

  logic        b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd;
  logic [1:0]  b_state, b_rem;
  logic [3:0]  b_sc, b_fc, b_fz;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.FLUSH_PENALTY(1), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .pipeline_stall(pipeline_stall), .stall_cycles(stall_cycles),
    .pipeline_flush(pipeline_flush), .mem_ready(mem_ready),
    .fetch_en(a_fe), .decode_en(a_de), .execute_en(a_ee), .writeback_en(a_we),
    .execute_bubble(a_bub), .flush_fetch(a_ff), .flush_decode(a_fd),
    .ctrl_state(a_state), .stall_remaining(a_rem),
    .stall_count(a_sc), .flush_count(a_fc), .freeze_count(a_fz)
  );

  pipeline_stall_controller #(.FLUSH_PENALTY(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .pipeline_stall(pipeline_stall), .stall_cycles(stall_cycles),
    .pipeline_flush(pipeline_flush), .mem_ready(mem_ready),
    .fetch_en(b_fe), .decode_en(b_de), .execute_en(b_ee), .writeback_en(b_we),
    .execute_bubble(b_bub), .flush_fetch(b_ff), .flush_decode(b_fd),
    .ctrl_state(b_state), .stall_remaining(b_rem),
    .stall_count(b_sc), .flush_count(b_fc), .freeze_count(b_fz)
  );

  // outs = {fetch_en, decode_en, execute_en, writeback_en, execute_bubble, flush_fetch, flush_decode}
  typedef struct {
    logic        rst;
    logic        st;
    logic [1:0]  sc;
    logic        fl;
    logic        mr;
    logic [6:0]  outs;
    logic [1:0]  state;
    logic [1:0]  rem;
    logic [31:0] sc_e;
    logic [31:0] fc_e;
    logic [31:0] fz_e;
  } vec_t;

  localparam logic [6:0] O_Z   = 7'b0000_000;
  localparam logic [6:0] O_RUN = 7'b1111_000;
  localparam logic [6:0] O_STL = 7'b0011_100;
  localparam logic [6:0] O_FL  = 7'b1111_111;

  localparam int unsigned NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic st, input logic [1:0] sc,
                              input logic fl, input logic mr, input logic [6:0] outs,
                              input logic [1:0] state, input logic [1:0] rem,
                              input int unsigned sce, input int unsigned fce,
                              input int unsigned fze);
    vec_t v;
    v.rst = r; v.st = st; v.sc = sc; v.fl = fl; v.mr = mr;
    v.outs = outs; v.state = state; v.rem = rem;
    v.sc_e = sce; v.fc_e = fce; v.fz_e = fze;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [1:0] sc,
                       input logic fl, input logic mr);
    @(negedge clk);
    rst = r; pipeline_stall = st; stall_cycles = sc; pipeline_flush = fl; mem_ready = mr;
    #2;
  endtask

  initial begin
    rst = 1'b1; pipeline_stall = 1'b0; stall_cycles = 2'd0; pipeline_flush = 1'b0; mem_ready = 1'b1;

    vecs[0]  = mk(1, 1, 2, 1, 1, O_Z,   0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 2, 0, 1, O_STL, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, O_STL, 1, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 2, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 1, O_STL, 0, 0, 2, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 3, 0, 0);
    vecs[7]  = mk(0, 1, 1, 1, 1, O_FL,  0, 0, 3, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 3, 1, 0);
    vecs[9]  = mk(0, 1, 3, 0, 1, O_STL, 0, 0, 3, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, O_Z,   1, 2, 4, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, O_Z,   1, 2, 4, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 1, O_STL, 1, 2, 4, 1, 2);
    vecs[13] = mk(0, 1, 3, 0, 1, O_STL, 1, 1, 5, 1, 2);
    vecs[14] = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 6, 1, 2);
    vecs[15] = mk(0, 1, 3, 0, 1, O_STL, 0, 0, 6, 1, 2);
    vecs[16] = mk(0, 1, 3, 1, 1, O_FL,  1, 2, 7, 1, 2);
    vecs[17] = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 7, 2, 2);
    vecs[18] = mk(0, 1, 2, 0, 1, O_STL, 0, 0, 7, 2, 2);
    vecs[19] = mk(1, 1, 2, 0, 1, O_Z,   1, 1, 8, 2, 2);
    vecs[20] = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, O_Z,   0, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 1, O_RUN, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].sc, vecs[i].fl, vecs[i].mr);
      chk($sformatf("row%0d_outs", i), {25'b0, a_fe, a_de, a_ee, a_we, a_bub, a_ff, a_fd},
          {25'b0, vecs[i].outs});
      chk($sformatf("row%0d_state", i), {30'b0, a_state}, {30'b0, vecs[i].state});
      chk($sformatf("row%0d_rem", i), {30'b0, a_rem}, {30'b0, vecs[i].rem});
      chk($sformatf("row%0d_stall_count", i), a_sc, vecs[i].sc_e);
      chk($sformatf("row%0d_flush_count", i), a_fc, vecs[i].fc_e);
      chk($sformatf("row%0d_freeze_count", i), a_fz, vecs[i].fz_e);
    end

    // FLUSH_PENALTY=3: back-to-back flushes restart the penalty, stall ignored in FLUSH.
    drive(0, 0, 0, 1, 1);
    chk("b_c0_outs", {25'b0, b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd}, {25'b0, O_FL});
    chk("b_c0_state", {30'b0, b_state}, 32'd0);
    drive(0, 0, 0, 1, 1);
    chk("b_c1_outs", {25'b0, b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd}, {25'b0, O_FL});
    chk("b_c1_state", {30'b0, b_state}, 32'd2);
    drive(0, 1, 3, 0, 1);
    chk("b_c2_outs", {25'b0, b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd}, 32'b1111_100);
    chk("b_c2_state", {30'b0, b_state}, 32'd2);
    drive(0, 0, 0, 0, 1);
    chk("b_c3_outs", {25'b0, b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd}, 32'b1111_100);
    chk("b_c3_state", {30'b0, b_state}, 32'd2);
    drive(0, 0, 0, 0, 1);
    chk("b_c4_outs", {25'b0, b_fe, b_de, b_ee, b_we, b_bub, b_ff, b_fd}, {25'b0, O_RUN});
    chk("b_c4_state", {30'b0, b_state}, 32'd0);
    chk("b_flush_count", {28'b0, b_fc}, 32'd2);
    chk("b_stall_count", {28'b0, b_sc}, 32'd0);

    // Long freeze: 4-bit counter saturates, 32-bit counter keeps counting.
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 1);
    chk("b_freeze_sat", {28'b0, b_fz}, 32'd15);
    chk("a_freeze_count", a_fz, 32'd21);
    chk("a_after_freeze_outs", {25'b0, a_fe, a_de, a_ee, a_we, a_bub, a_ff, a_fd}, {25'b0, O_RUN});
    chk("b_after_freeze_state", {30'b0, b_state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
